// File: rtl/req_cond_pkg.sv
// Shared types and defaults for the request conditioner: FSM encoding,
// source identifiers and default parameter values.
package req_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10,
    ST_GAP  = 2'b11
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_HOLD_CYCLES = 2;
  localparam int DEF_TIMEOUT     = 8;
  localparam int DEF_CNT_W       = 3;

endpackage

// File: rtl/req_conditioner_if.sv
// Bundle of request-side signals between raw sources, the conditioner and the
// downstream grant FSM.
interface req_conditioner_if
  import req_cond_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  // Handshake: req is a level held from REQ through HOLD; ack (downstream
  // gnt_0) is honoured only while in REQ and retires exactly one event of src_id.
  logic             raw_a;
  logic             raw_b;
  logic             ack;
  logic             req;
  logic             src_id;
  logic [CNT_W-1:0] pend_a;
  logic [CNT_W-1:0] pend_b;
  logic             ovf;
  logic             timeout_err;

  modport master (
    input  raw_a, raw_b, ack,
    output req, src_id, pend_a, pend_b, ovf, timeout_err
  );

  modport slave (
    output raw_a, raw_b, ack,
    input  req, src_id, pend_a, pend_b, ovf, timeout_err
  );

endinterface

// File: rtl/req_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one raw request line;
// emits a single-cycle pulse in the cycle the debounced level rises.
module req_debounce
  import req_cond_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic deb_level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_1;
  logic          sync_x;
  logic [CW-1:0] stable_cnt;
  logic          settle;

  // Settle on the DEB_CYCLES-th consecutive cycle of disagreement.
  assign settle     = (sync_x != deb_level) && (stable_cnt == CW'(DEB_CYCLES - 1));
  assign rise_pulse = settle && sync_x;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_1     <= 1'b0;
      sync_x     <= 1'b0;
      deb_level  <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_1 <= raw;
      sync_x <= sync_1;
      if (sync_x == deb_level) begin
        stable_cnt <= '0;
      end else if (settle) begin
        deb_level  <= sync_x;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_conditioner.sv
// Request front-end: debounces two sources, counts pending events and serves
// them round-robin as a single req level acknowledged by the grant FSM.
module req_conditioner
  import req_cond_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  req_conditioner_if.master  bus,
  output state_t             state_dbg,
  output logic [1:0]         deb_dbg
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic deb_a, deb_b, rise_a, rise_b;

  req_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clock      (clock),
    .reset      (reset),
    .raw        (bus.raw_a),
    .deb_level  (deb_a),
    .rise_pulse (rise_a)
  );

  req_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clock      (clock),
    .reset      (reset),
    .raw        (bus.raw_b),
    .deb_level  (deb_b),
    .rise_pulse (rise_b)
  );

  state_t              state, state_n;
  logic                src_q, src_n;
  logic                last_src, last_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic                retire, to_hit;
  logic [CNT_W-1:0]    pend_a_q, pend_b_q;
  logic                ovf_q, to_err_q;
  logic                ret_a, ret_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      src_q    <= SRC_A;
      last_src <= SRC_A;
      timer    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      src_q    <= src_n;
      last_src <= last_n;
      timer    <= timer_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    src_n   = src_q;
    last_n  = last_src;
    timer_n = timer;
    hold_n  = hold_cnt;
    retire  = 1'b0;
    to_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pend_a_q != '0) || (pend_b_q != '0)) begin
          state_n = ST_REQ;
          timer_n = '0;
          // Contention goes to whichever source was not served last.
          if ((pend_a_q != '0) && (pend_b_q != '0)) begin
            src_n = ~last_src;
          end else begin
            src_n = (pend_b_q != '0) ? SRC_B : SRC_A;
          end
          last_n = src_n;
        end
      end
      ST_REQ: begin
        if (bus.ack) begin
          retire  = 1'b1;
          state_n = ST_HOLD;
          hold_n  = '0;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          state_n = ST_GAP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_n = ST_GAP;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign ret_a = retire && (src_q == SRC_A);
  assign ret_b = retire && (src_q == SRC_B);

  // An event and a retire on the same source in one cycle cancel out.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_a_q <= '0;
      pend_b_q <= '0;
      ovf_q    <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      if (rise_a && !ret_a) begin
        if (pend_a_q == PEND_MAX) ovf_q <= 1'b1;
        else                      pend_a_q <= pend_a_q + 1'b1;
      end else if (ret_a && !rise_a) begin
        pend_a_q <= pend_a_q - 1'b1;
      end
      if (rise_b && !ret_b) begin
        if (pend_b_q == PEND_MAX) ovf_q <= 1'b1;
        else                      pend_b_q <= pend_b_q + 1'b1;
      end else if (ret_b && !rise_b) begin
        pend_b_q <= pend_b_q - 1'b1;
      end
      if (to_hit) to_err_q <= 1'b1;
    end
  end

  assign bus.req         = (state == ST_REQ) || (state == ST_HOLD);
  assign bus.src_id      = src_q;
  assign bus.pend_a      = pend_a_q;
  assign bus.pend_b      = pend_b_q;
  assign bus.ovf         = ovf_q;
  assign bus.timeout_err = to_err_q;
  assign state_dbg       = state;
  assign deb_dbg         = {deb_b, deb_a};

endmodule
